mux_frame_shifter: RTL and testbench

- Serializes one parallel control word onto the multiplexer serial line, MSB first.
- Generates the `clockEnable` strobe that gates the downstream clock divider, so the divided clock toggles only while a frame is on the wire.
- Bit timing uses the same `N_div` ratio the divider receives, so every data bit is aligned to one divided-clock period.
- Sits between the register/command interface (upstream) and the clock divider plus output pins (downstream).

---
 rtl/mux_pkg.sv | 23 ++
 rtl/bit_period_timer.sv | 29 ++
 rtl/mux_frame_shifter.sv | 144 ++++++++++++++
 tb/tb_mux_frame_shifter.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mux_pkg.sv
// Shared types and helpers for the multiplexer frame shifter.
package mux_pkg;

    localparam int unsigned DIV_W = 4;
    localparam int unsigned PER_W = 5;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LEAD  = 3'd1,
        S_SHIFT = 3'd2,
        S_TRAIL = 3'd3,
        S_GAP   = 3'd4
    } mux_shift_state_t;

    // Bit period in clk_in cycles: 2*N_div, with N_div=0 meaning one cycle per bit.
    function automatic logic [PER_W-1:0] bit_period(input logic [DIV_W-1:0] n_div);
        if (n_div == '0) begin
            return PER_W'(1);
        end
        return {n_div, 1'b0};
    endfunction

endpackage

// File: rtl/bit_period_timer.sv
// Counts clk_in cycles within one serial bit and flags the last cycle of each bit.
module bit_period_timer
    import mux_pkg::*;
(
    input  logic             clk_in,
    input  logic             rst,
    input  logic [DIV_W-1:0] n_div,
    input  logic             en,
    output logic             bit_end
);

    logic [PER_W-1:0] cnt;
    logic [PER_W-1:0] last;

    assign last    = bit_period(n_div) - PER_W'(1);
    assign bit_end = en && (cnt == last);

    // Period counter: held at zero while disabled, reloads at every bit boundary.
    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (!en || bit_end) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + PER_W'(1);
        end
    end

endmodule

// File: rtl/mux_frame_shifter.sv
// Serializes one control word MSB first onto the multiplexer line and gates the
// downstream divider through clockEnable for exactly the bit window.
// Optional build macro MUX_FRAME_PARITY_EN appends one odd-parity bit after the LSB.
module mux_frame_shifter
    import mux_pkg::*;
#(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned GAP   = 2
) (
    input  logic             clk_in,
    input  logic             rst,
    input  logic [DIV_W-1:0] N_div,
    input  logic             start,
    input  logic [WIDTH-1:0] data_in,
    output logic             ready,
    output logic             done,
    output logic             clockEnable,
    output logic             cs_n,
    output logic             sdo
);

`ifdef MUX_FRAME_PARITY_EN
    localparam int unsigned NB = WIDTH + 1;
`else
    localparam int unsigned NB = WIDTH;
`endif
    localparam int unsigned BIT_CNT_W = $clog2(NB);
    localparam int unsigned GAP_CNT_W = $clog2(GAP + 1);

    mux_shift_state_t       state;
    mux_shift_state_t       state_nxt;
    logic [NB-1:0]          frame_word;
    logic [NB-1:0]          shreg;
    logic [BIT_CNT_W-1:0]   bit_cnt;
    logic [GAP_CNT_W-1:0]   gap_cnt;
    logic [DIV_W-1:0]       n_div_q;
    logic                   bit_end;

    logic                   ready_nxt;
    logic                   done_nxt;
    logic                   ce_nxt;
    logic                   cs_n_nxt;
    logic                   sdo_nxt;

    // Frame contents as latched at start; parity is taken over the word being latched.
`ifdef MUX_FRAME_PARITY_EN
    assign frame_word = {data_in, ~^data_in};
`else
    assign frame_word = data_in;
`endif

    bit_period_timer u_timer (
        .clk_in  (clk_in),
        .rst     (rst),
        .n_div   (n_div_q),
        .en      (state == S_SHIFT),
        .bit_end (bit_end)
    );

    // State register.
    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic: one-cycle LEAD and TRAIL framing a bit-timed SHIFT, then GAP.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (start) state_nxt = S_LEAD;
            S_LEAD:  state_nxt = S_SHIFT;
            S_SHIFT: if (bit_end && (bit_cnt == '0)) state_nxt = S_TRAIL;
            S_TRAIL: state_nxt = S_GAP;
            S_GAP:   if (gap_cnt == GAP_CNT_W'(GAP - 1)) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Output decode: next values for the registered pins, derived from the coming state.
    always_comb begin
        ready_nxt = (state_nxt == S_IDLE);
        done_nxt  = (state == S_TRAIL);
        ce_nxt    = (state_nxt == S_SHIFT);
        cs_n_nxt  = (state_nxt == S_IDLE) || (state_nxt == S_GAP);
        sdo_nxt   = sdo;
        case (state_nxt)
            S_LEAD:  sdo_nxt = frame_word[NB-1];
            S_SHIFT: if (bit_end) sdo_nxt = shreg[NB-2];
            S_IDLE,
            S_GAP:   sdo_nxt = 1'b0;
            default: sdo_nxt = sdo;
        endcase
    end

    // Frame datapath: latch word and divide ratio, shift per bit, count gap cycles.
    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            shreg   <= '0;
            n_div_q <= '0;
            bit_cnt <= '0;
            gap_cnt <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        shreg   <= frame_word;
                        n_div_q <= N_div;
                        bit_cnt <= BIT_CNT_W'(NB - 1);
                    end
                end
                S_SHIFT: begin
                    if (bit_end) begin
                        shreg   <= shreg << 1;
                        bit_cnt <= bit_cnt - BIT_CNT_W'(1);
                    end
                end
                S_TRAIL: gap_cnt <= '0;
                S_GAP:   gap_cnt <= gap_cnt + GAP_CNT_W'(1);
                default: ;
            endcase
        end
    end

    // Output registers: pins change only on rising clk_in edges.
    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            ready       <= 1'b1;
            done        <= 1'b0;
            clockEnable <= 1'b0;
            cs_n        <= 1'b1;
            sdo         <= 1'b0;
        end else begin
            ready       <= ready_nxt;
            done        <= done_nxt;
            clockEnable <= ce_nxt;
            cs_n        <= cs_n_nxt;
            sdo         <= sdo_nxt;
        end
    end

endmodule

// File: tb/tb_mux_frame_shifter.sv
// Self-checking bench for mux_frame_shifter: cycle-accurate frame model plus
// directed and randomized frames.
module tb_mux_frame_shifter;

    localparam int unsigned WIDTH = 16;
    localparam int unsigned GAP   = 2;

    logic             clk_in;
    logic             rst;
    logic [3:0]       N_div;
    logic             start;
    logic [WIDTH-1:0] data_in;
    logic             ready;
    logic             done;
    logic             clockEnable;
    logic             cs_n;
    logic             sdo;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    mux_frame_shifter #(.WIDTH(WIDTH), .GAP(GAP)) dut (
        .clk_in      (clk_in),
        .rst         (rst),
        .N_div       (N_div),
        .start       (start),
        .data_in     (data_in),
        .ready       (ready),
        .done        (done),
        .clockEnable (clockEnable),
        .cs_n        (cs_n),
        .sdo         (sdo)
    );

    initial begin
        clk_in = 1'b0;
        forever #5 clk_in = ~clk_in;
    end

    always @(posedge clk_in) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h time=%0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: a frame is described by its offset m_t in cycles from the
    // accepting edge; the expected pins follow from the frame timeline.
    bit          m_active = 1'b0;
    int          m_t      = 0;
    int          m_p      = 1;
    int          m_nb     = WIDTH;
    logic [32:0] m_fw     = '0;

    always @(posedge clk_in or posedge rst) begin
        if (rst) begin
            m_active = 1'b0;
        end else if (!m_active) begin
            if (start) begin
                m_active = 1'b1;
                m_t      = 1;
                m_p      = (N_div == 4'd0) ? 1 : 2 * int'(N_div);
`ifdef MUX_FRAME_PARITY_EN
                m_nb = WIDTH + 1;
                m_fw = 33'({data_in, 1'(($countones(data_in) % 2) == 0)});
`else
                m_nb = WIDTH;
                m_fw = 33'(data_in);
`endif
            end
        end else begin
            m_t++;
            if (m_t >= 3 + m_nb * m_p + int'(GAP)) m_active = 1'b0;
        end
    end

    function automatic void mdl_expect(output logic e_ready, output logic e_done,
                                       output logic e_ce, output logic e_cs_n,
                                       output logic e_sdo);
        int shift_end;
        e_ready = 1'b1; e_done = 1'b0; e_ce = 1'b0; e_cs_n = 1'b1; e_sdo = 1'b0;
        if (m_active) begin
            e_ready   = 1'b0;
            shift_end = 2 + m_nb * m_p;
            if (m_t == 1) begin
                e_cs_n = 1'b0;
                e_sdo  = m_fw[m_nb-1];
            end else if (m_t < shift_end) begin
                e_cs_n = 1'b0;
                e_ce   = 1'b1;
                e_sdo  = m_fw[m_nb - 1 - (m_t - 2) / m_p];
            end else if (m_t == shift_end) begin
                e_cs_n = 1'b0;
                e_sdo  = m_fw[0];
            end else begin
                e_done = (m_t == shift_end + 1);
            end
        end
    endfunction

    // Per-cycle comparison against the model plus frame-level window measurements.
    logic e_ready, e_done, e_ce, e_cs_n, e_sdo;
    logic prev_cs_n = 1'b1;
    logic prev_ready = 1'b1;
    bit   done_seen = 1'b0;
    int   frame_cyc = 0;
    int   done_cyc  = 0;
    int   ce_cnt    = 0;

    always @(negedge clk_in) begin
        mdl_expect(e_ready, e_done, e_ce, e_cs_n, e_sdo);
        check("ready", 32'(ready), 32'(e_ready));
        check("done", 32'(done), 32'(e_done));
        check("clockEnable", 32'(clockEnable), 32'(e_ce));
        check("cs_n", 32'(cs_n), 32'(e_cs_n));
        check("sdo", 32'(sdo), 32'(e_sdo));
        check("done_ready_excl", 32'(done & ready), 32'(0));
        if (rst) begin
            done_seen = 1'b0;
        end else begin
            if (prev_cs_n && !cs_n) begin
                frame_cyc = cyc;
                ce_cnt    = 0;
            end
            if (clockEnable) ce_cnt++;
            if (done) begin
                check("ce_window", 32'(ce_cnt), 32'(m_nb * m_p));
                check("done_latency", 32'(cyc - frame_cyc + 1), 32'(3 + m_nb * m_p));
                done_cyc  = cyc;
                done_seen = 1'b1;
            end
            if (ready && !prev_ready && done_seen) begin
                check("gap_to_ready", 32'(cyc - done_cyc), 32'(GAP));
                done_seen = 1'b0;
            end
        end
        prev_cs_n  = cs_n;
        prev_ready = ready;
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk_in);
            #1;
        end
    endtask

    // Present one start pulse, then scramble the inputs to prove they were latched.
    task automatic send_frame(input logic [WIDTH-1:0] d, input logic [3:0] n);
        data_in = d;
        N_div   = n;
        start   = 1'b1;
        step(1);
        start   = 1'b0;
        data_in = WIDTH'($urandom);
        N_div   = 4'($urandom);
    endtask

    task automatic wait_ready(input int budget);
        int n = 0;
        while (!ready && n < budget) begin
            step(1);
            n++;
        end
        if (!ready) check("ready_timeout", 32'(ready), 32'(1));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired time=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        rst     = 1'b0;
        start   = 1'b0;
        N_div   = '0;
        data_in = '0;
        #1 rst = 1'b1;
        #2;
        check("rst_ready", 32'(ready), 32'(1));
        check("rst_done", 32'(done), 32'(0));
        check("rst_ce", 32'(clockEnable), 32'(0));
        check("rst_cs_n", 32'(cs_n), 32'(1));
        check("rst_sdo", 32'(sdo), 32'(0));
        step(3);
        rst = 1'b0;
        step(2);

        // Reference frames.
        send_frame(16'hA5C3, 4'd2);
        wait_ready(1000);
        step(3);
        send_frame(16'h8001, 4'd0);
        wait_ready(1000);
        step(2);
        send_frame(16'h0003, 4'd1);
        wait_ready(1000);
        step(2);

        // Back-to-back: restart on the cycle ready returns.
        send_frame(16'h1357, 4'd1);
        wait_ready(1000);
        send_frame(16'hFFFF, 4'd0);
        wait_ready(1000);
        send_frame(16'h0000, 4'd3);
        wait_ready(1000);
        step(2);

        // Start and N_div changes during SHIFT are ignored.
        send_frame(WIDTH'($urandom), 4'd1);
        step(6);
        start   = 1'b1;
        N_div   = 4'd7;
        data_in = WIDTH'($urandom);
        step(1);
        start   = 1'b0;
        wait_ready(1000);
        step(6);

        // Asynchronous reset in mid-SHIFT, then an immediate restart.
        send_frame(WIDTH'($urandom), 4'd3);
        step(20);
        #1 rst = 1'b1;
        #1;
        check("abort_ready", 32'(ready), 32'(1));
        check("abort_done", 32'(done), 32'(0));
        check("abort_ce", 32'(clockEnable), 32'(0));
        check("abort_cs_n", 32'(cs_n), 32'(1));
        check("abort_sdo", 32'(sdo), 32'(0));
        step(1);
        rst = 1'b0;
        send_frame(16'h1234, 4'd2);
        wait_ready(1000);
        step(2);

        // Randomized frames with random idle spacing, including back-to-back.
        for (int i = 0; i < 20; i++) begin
            send_frame(WIDTH'($urandom), 4'($urandom_range(0, 15)));
            wait_ready(1200);
            step($urandom_range(0, 3));
        end
        step(4);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
